ice40_ram_fifo: RTL and testbench

Parametrised synchronous FIFO on iCE40 block RAM, the successor to the fixed 256x16 single-instance RAM wrapper. Width and depth are generic. The block uses valid/ready handshakes on both sides, first-word fall-through output, occupancy count, almost-full/almost-empty flags and a synchronous flush. Storage is a simple-dual-port RAM with a 1-cycle registered read that holds its output while the read enable is low, matching SB_RAM40_4K READ_MODE 0. It sits between streaming producers and consumers in a single clock domain.

---
 rtl/ice40_ram_pkg.sv | 31 +++
 rtl/ice40_ram_sdp.sv | 27 ++
 rtl/ice40_ram_fifo.sv | 84 ++++++++
 tb/tb_ice40_ram_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ice40_ram_pkg.sv
// rtl/ice40_ram_pkg.sv - iCE40 block RAM mode encodings, tile constants and tile-count helper
package ice40_ram_pkg;

  typedef enum logic [1:0] {
    RAM_256X16 = 2'd0,
    RAM_512X8  = 2'd1,
    RAM_1024X4 = 2'd2,
    RAM_2048X2 = 2'd3
  } ram_mode_e;

  localparam int BRAM_BITS   = 4096;
  localparam int BRAM_MIN_AW = 8;
  localparam int BRAM_MAX_AW = 11;

  function automatic ram_mode_e ram_mode(input int aw);
    if (aw <= 8) return RAM_256X16;
    else if (aw == 9) return RAM_512X8;
    else if (aw == 10) return RAM_1024X4;
    return RAM_2048X2;
  endfunction

  // Shallow FIFOs still occupy a full 256-deep tile, so depth is clamped up first.
  function automatic int bram_tiles(input int width, input int aw);
    int eff_aw;
    int tile_w;
    eff_aw = (aw < BRAM_MIN_AW) ? BRAM_MIN_AW : aw;
    tile_w = BRAM_BITS >> eff_aw;
    return (width + tile_w - 1) / tile_w;
  endfunction

endpackage

// File: rtl/ice40_ram_sdp.sv
// rtl/ice40_ram_sdp.sv - simple-dual-port RAM with registered read that holds while re is low
module ice40_ram_sdp #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ice40_ram_fifo.sv
// rtl/ice40_ram_fifo.sv - first-word fall-through FIFO on iCE40 block RAM
module ice40_ram_fifo
  import ice40_ram_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int AW               = 8,
  parameter int ALMOST_FULL_LVL  = (2**AW) - 4,
  parameter int ALMOST_EMPTY_LVL = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             WVALID,
  output logic             WREADY,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  input  logic             RREADY,
  output logic [AW:0]      COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);
  localparam logic [AW:0] AF_LVL  = (AW+1)'(ALMOST_FULL_LVL);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(ALMOST_EMPTY_LVL);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   ram_cnt_q, ram_cnt_nxt, count_nxt;
  logic          push, pop, re;

  // ram_cnt tracks words still in the RAM; COUNT also includes the fetched head word.
  always_comb begin
    push        = WVALID && WREADY;
    pop         = RVALID && RREADY;
    re          = (ram_cnt_q != '0) && (!RVALID || RREADY) && !RESET && !FLUSH;
    count_nxt   = COUNT + (AW+1)'(push) - (AW+1)'(pop);
    ram_cnt_nxt = ram_cnt_q + (AW+1)'(push) - (AW+1)'(re);
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      ram_cnt_q    <= '0;
      COUNT        <= '0;
      RVALID       <= 1'b0;
      WREADY       <= !RESET;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= (AF_LVL == '0);
      ALMOST_EMPTY <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (re)   rptr_q <= rptr_q + AW'(1);
      if (re)        RVALID <= 1'b1;
      else if (pop)  RVALID <= 1'b0;
      ram_cnt_q    <= ram_cnt_nxt;
      COUNT        <= count_nxt;
      WREADY       <= (count_nxt != DEPTH_C);
      FULL         <= (count_nxt == DEPTH_C);
      EMPTY        <= (count_nxt == '0);
      ALMOST_FULL  <= (count_nxt >= AF_LVL);
      ALMOST_EMPTY <= (count_nxt <= AE_LVL);
    end
  end

  ice40_ram_sdp #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .rst   (RESET),
    .we    (push && !RESET && !FLUSH),
    .waddr (wptr_q),
    .wdata (WDATA),
    .re    (re),
    .raddr (rptr_q),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_ice40_ram_fifo.sv
// tb/tb_ice40_ram_fifo.sv - scoreboard bench for ice40_ram_fifo
module tb_ice40_ram_fifo;

  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             CLK = 1'b0;
  logic             RESET, FLUSH, WVALID, RREADY;
  logic             WREADY, RVALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
  logic [WIDTH-1:0] WDATA, RDATA;
  logic [AW:0]      COUNT;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             hold_prev = 1'b0;
  logic             disc_prev = 1'b1;
  logic [WIDTH-1:0] data_prev = '0;

  always #5 CLK = ~CLK;

  ice40_ram_fifo #(
    .WIDTH            (WIDTH),
    .AW               (AW),
    .ALMOST_FULL_LVL  (12),
    .ALMOST_EMPTY_LVL (4)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FLUSH        (FLUSH),
    .WDATA        (WDATA),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .RDATA        (RDATA),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .COUNT        (COUNT),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Producer side: record every word the next edge will accept.
  always @(negedge CLK) begin
    if (RESET || FLUSH) exp_q.delete();
    else if (WVALID && WREADY === 1'b1) exp_q.push_back(WDATA);
  end

  // Consumer side: compare popped words and check stall stability.
  always @(negedge CLK) begin
    if (hold_prev && !disc_prev) begin
      check("hold_rvalid", 32'(RVALID), 32'd1);
      check("hold_rdata", 32'(RDATA), 32'(data_prev));
    end
    if (RVALID === 1'b1 && RREADY && !RESET && !FLUSH) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_underflow: got 0x%0h, expected no word", RDATA);
      end else begin
        check("pop_data", 32'(RDATA), 32'(exp_q.pop_front()));
      end
    end
    hold_prev = (RVALID === 1'b1) && !RREADY;
    data_prev = RDATA;
    disc_prev = RESET || FLUSH;
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    RREADY = 1'b1;
    while ((COUNT !== '0 || RVALID !== 1'b0) && k < 200) begin
      tick();
      k++;
    end
    RREADY = 1'b0;
    check(name, 32'(COUNT), 32'd0);
  endtask

  task automatic drain_random(input string name);
    int k;
    k = 0;
    while ((COUNT !== '0 || RVALID !== 1'b0) && k < 400) begin
      RREADY = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    RREADY = 1'b0;
    check(name, 32'(COUNT), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int idx;
    int guard;
    int pops0;
    logic acc;

    RESET = 1'b1; FLUSH = 1'b0; WVALID = 1'b0; RREADY = 1'b0; WDATA = '0;
    tick(); tick();
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_aempty", 32'(ALMOST_EMPTY), 32'd1);
    check("rst_afull", 32'(ALMOST_FULL), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    RESET = 1'b0;
    tick();
    check("post_rst_wready", 32'(WREADY), 32'd1);

    // Four pushes with consumer stalled.
    WVALID = 1'b1; WDATA = 16'h0001; tick();
    check("t1_rvalid_n", 32'(RVALID), 32'd0);
    WDATA = 16'h0002; tick();
    check("t1_rvalid_n1", 32'(RVALID), 32'd1);
    check("t1_rdata_n1", 32'(RDATA), 32'h0001);
    WDATA = 16'h0003; tick();
    WDATA = 16'h0004; tick();
    WVALID = 1'b0;
    check("t1_count", 32'(COUNT), 32'd4);
    check("t1_aempty", 32'(ALMOST_EMPTY), 32'd1);
    tick(); tick();
    check("t1_rdata_held", 32'(RDATA), 32'h0001);
    drain("t1_drain");

    // Fill to DEPTH, reject a 17th, then one pop.
    for (int i = 0; i < 16; i++) begin
      WVALID = 1'b1; WDATA = 16'(16'h0100 + i); tick();
    end
    WVALID = 1'b0;
    check("t2_full", 32'(FULL), 32'd1);
    check("t2_wready", 32'(WREADY), 32'd0);
    check("t2_count", 32'(COUNT), 32'd16);
    check("t2_afull", 32'(ALMOST_FULL), 32'd1);
    WVALID = 1'b1; WDATA = 16'hDEAD; tick(); WVALID = 1'b0;
    check("t2_no_17th", 32'(COUNT), 32'd16);
    RREADY = 1'b1; tick(); RREADY = 1'b0;
    check("t2_full_after_pop", 32'(FULL), 32'd0);
    check("t2_wready_after_pop", 32'(WREADY), 32'd1);
    check("t2_count_after_pop", 32'(COUNT), 32'd15);
    drain("t2_drain");

    // Sustained push and pop across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      WVALID = 1'b1; WDATA = 16'(16'h0200 + i); tick();
    end
    WVALID = 1'b0;
    tick(); tick();
    check("t3_preload", 32'(COUNT), 32'd3);
    pops0 = n_pops;
    RREADY = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 64; i++) begin
      WDATA = 16'(16'h0300 + i);
      tick();
      check("t3_count", 32'(COUNT), 32'd3);
      check("t3_rvalid", 32'(RVALID), 32'd1);
    end
    WVALID = 1'b0; RREADY = 1'b0;
    check("t3_pops", 32'(n_pops - pops0), 32'd64);
    drain("t3_drain");

    // Random consumer backpressure.
    idx = 0; guard = 0;
    while (idx < 20 && guard < 300) begin
      WDATA = 16'(16'h0400 + idx);
      WVALID = 1'b1;
      RREADY = 1'($urandom_range(0, 1));
      acc = WREADY;
      tick();
      if (acc) idx++;
      guard++;
    end
    WVALID = 1'b0;
    check("t4_pushed", 32'(idx), 32'd20);
    drain_random("t4_drain");

    // Flush with seven words held and a simultaneous push.
    for (int i = 0; i < 7; i++) begin
      WVALID = 1'b1; WDATA = 16'(16'h0500 + i); tick();
    end
    WVALID = 1'b0;
    tick();
    check("t5_count_pre", 32'(COUNT), 32'd7);
    FLUSH = 1'b1; WVALID = 1'b1; WDATA = 16'h0BAD; tick();
    FLUSH = 1'b0; WVALID = 1'b0;
    check("t5_count", 32'(COUNT), 32'd0);
    check("t5_empty", 32'(EMPTY), 32'd1);
    check("t5_rvalid", 32'(RVALID), 32'd0);
    check("t5_wready", 32'(WREADY), 32'd1);
    tick(); tick();
    check("t5_rvalid_idle", 32'(RVALID), 32'd0);
    check("t5_count_idle", 32'(COUNT), 32'd0);
    WVALID = 1'b1; WDATA = 16'h5A5A; tick(); WVALID = 1'b0;
    tick();
    check("t5_refill_rvalid", 32'(RVALID), 32'd1);
    check("t5_refill_rdata", 32'(RDATA), 32'h5A5A);
    check("t5_refill_count", 32'(COUNT), 32'd1);
    drain("t5_drain");

    // Reset mid-stream with nine words held.
    for (int i = 0; i < 9; i++) begin
      WVALID = 1'b1; WDATA = 16'(16'h0600 + i); tick();
    end
    WVALID = 1'b0;
    tick();
    check("t6_count_pre", 32'(COUNT), 32'd9);
    RESET = 1'b1; WVALID = 1'b1; WDATA = 16'hBEEF; tick();
    check("t6_count", 32'(COUNT), 32'd0);
    check("t6_rdata", 32'(RDATA), 32'd0);
    check("t6_wready", 32'(WREADY), 32'd0);
    check("t6_rvalid", 32'(RVALID), 32'd0);
    check("t6_empty", 32'(EMPTY), 32'd1);
    RESET = 1'b0; WVALID = 1'b0; tick();
    check("t6_wready_after", 32'(WREADY), 32'd1);
    check("t6_count_after", 32'(COUNT), 32'd0);
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
